// File: rtl/filter_scan_ctrl.sv
// filter_scan_ctrl: round-robin hold filter shared across CHANNELS command
// inputs. Each clock visits one channel, reloads or decays its hold counter,
// and queues a level-change event that is reported over a valid/ready port.
module filter_scan_ctrl #(
  parameter int CHANNELS     = 8,
  parameter int FILTER_WIDTH = 2,
  parameter int CH_W         = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                en,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_ch,
  output logic                evt_level,
  output logic                scan_wrap
);

  localparam logic [FILTER_WIDTH-1:0] CNT_FULL = '1;
  localparam logic [CH_W-1:0]         PTR_LAST = CH_W'(CHANNELS - 1);

  logic [FILTER_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CH_W-1:0]         ptr_q, ptr_d;
  logic [CHANNELS-1:0]     out_q, out_d;
  logic [CHANNELS-1:0]     pending_q, pending_d;
  logic                    evtValid_q, evtValid_d;
  logic [CH_W-1:0]         evtCh_q, evtCh_d;
  logic                    evtLevel_q, evtLevel_d;
  logic                    scanWrap_q, scanWrap_d;

  logic [FILTER_WIDTH-1:0] visitCnt_d;
  logic                    visitLevel;
  logic                    visitChange;
  logic                    pickFound;
  logic [CH_W-1:0]         pickIdx;

  // Update rule for the channel under the pointer: reload on an active input,
  // otherwise count down and stick at zero; the level is "counter not empty".
  always_comb begin
    visitCnt_d = cnt_q[ptr_q];
    if (in[ptr_q]) begin
      visitCnt_d = CNT_FULL;
    end else if (cnt_q[ptr_q] != '0) begin
      visitCnt_d = cnt_q[ptr_q] - FILTER_WIDTH'(1);
    end
    visitLevel  = (visitCnt_d != '0);
    visitChange = en && (visitLevel != out_q[ptr_q]);

    out_d = out_q;
    if (en) begin
      out_d[ptr_q] = visitLevel;
    end

    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + CH_W'(1);
    end
    scanWrap_d = en && (ptr_q == PTR_LAST);
  end

  // Event port: finish a handshake, or else load the lowest pending channel;
  // a fresh change from this cycle's visit is recorded after the load clear so
  // that a channel reloaded and re-changed in the same cycle is not lost.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pickFound = 1'b1;
        pickIdx   = CH_W'(i);
      end
    end

    pending_d  = pending_q;
    evtValid_d = evtValid_q;
    evtCh_d    = evtCh_q;
    evtLevel_d = evtLevel_q;

    if (evtValid_q) begin
      if (evt_ready) begin
        evtValid_d = 1'b0;
      end
    end else if (pickFound) begin
      evtValid_d         = 1'b1;
      evtCh_d            = pickIdx;
      evtLevel_d         = out_q[pickIdx];
      pending_d[pickIdx] = 1'b0;
    end

    if (visitChange) begin
      pending_d[ptr_q] = 1'b1;
    end
  end

  // State registers with synchronous reset to the "all held high" condition.
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= CNT_FULL;
      end
      ptr_q      <= '0;
      out_q      <= '1;
      pending_q  <= '0;
      evtValid_q <= 1'b0;
      evtCh_q    <= '0;
      evtLevel_q <= 1'b0;
      scanWrap_q <= 1'b0;
    end else begin
      if (en) begin
        cnt_q[ptr_q] <= visitCnt_d;
      end
      ptr_q      <= ptr_d;
      out_q      <= out_d;
      pending_q  <= pending_d;
      evtValid_q <= evtValid_d;
      evtCh_q    <= evtCh_d;
      evtLevel_q <= evtLevel_d;
      scanWrap_q <= scanWrap_d;
    end
  end

  assign out       = out_q;
  assign evt_valid = evtValid_q;
  assign evt_ch    = evtCh_q;
  assign evt_level = evtLevel_q;
  assign scan_wrap = scanWrap_q;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// tb_filter_scan_ctrl: bench for filter_scan_ctrl at CHANNELS=4,
// FILTER_WIDTH=2 (hold of 3 visits, 12 cycles).
module tb_filter_scan_ctrl;

  logic       clk = 1'b0;
  logic       aclr;
  logic       en;
  logic [3:0] inBits;
  logic [3:0] outBits;
  logic       evtValid;
  logic       evtReady;
  logic [1:0] evtCh;
  logic       evtLevel;
  logic       scanWrap;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       en;
    logic [3:0] inBits;
    logic       ready;
    logic [3:0] expOut;
    logic       expWrap;
    logic       expValid;
    logic [1:0] expCh;
    logic       expLevel;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic       level;
  } evt_t;

  vec_t vecs [18];
  evt_t expQ [$];

  filter_scan_ctrl #(
    .CHANNELS    (4),
    .FILTER_WIDTH(2)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .en       (en),
    .in       (inBits),
    .out      (outBits),
    .evt_valid(evtValid),
    .evt_ready(evtReady),
    .evt_ch   (evtCh),
    .evt_level(evtLevel),
    .scan_wrap(scanWrap)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; if a handshake will complete
  // at the next rising edge, pop the scoreboard and compare the presented event.
  task automatic applyStimulus(input logic a, input logic e, input logic [3:0] i, input logic r);
    evt_t exp;
    aclr     = a;
    en       = e;
    inBits   = i;
    evtReady = r;
    if (!a && evtValid === 1'b1 && r) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL evtUnexpected: got ch=%0d level=%0d, expected no event", evtCh, evtLevel);
      end else begin
        exp = expQ.pop_front();
        checkOutput("evtCh", 32'(evtCh), 32'(exp.ch));
        checkOutput("evtLevel", 32'(evtLevel), 32'(exp.level));
      end
    end
    @(negedge clk);
  endtask

  function automatic evt_t mkEvt(input logic [1:0] ch, input logic level);
    evt_t e;
    e.ch    = ch;
    e.level = level;
    return e;
  endfunction

  initial begin
    logic [3:0] frzOut [13];
    logic [3:0] stim;
    logic       rdy;

    // Release-decay vectors: edge k visits channel k mod 4 with in=0.
    vecs[0]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'h0, 1'b1, 4'hC, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[13] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[14] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0};
    vecs[16] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0};

    frzOut = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    aclr = 1'b1; en = 1'b0; inBits = 4'h0; evtReady = 1'b0;
    @(negedge clk);

    // Reset state
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("rstOut", 32'(outBits), 32'hF);
    checkOutput("rstValid", 32'(evtValid), 32'h0);
    checkOutput("rstWrap", 32'(scanWrap), 32'h0);
    checkOutput("rstCh", 32'(evtCh), 32'h0);
    checkOutput("rstLevel", 32'(evtLevel), 32'h0);

    // Release decay from reset
    for (int c = 0; c < 4; c++) expQ.push_back(mkEvt(2'(c), 1'b0));
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b0, vecs[k].en, vecs[k].inBits, vecs[k].ready);
      checkOutput($sformatf("decayOut[%0d]", k), 32'(outBits), 32'(vecs[k].expOut));
      checkOutput($sformatf("decayWrap[%0d]", k), 32'(scanWrap), 32'(vecs[k].expWrap));
      checkOutput($sformatf("decayValid[%0d]", k), 32'(evtValid), 32'(vecs[k].expValid));
      if (vecs[k].expValid) begin
        checkOutput($sformatf("decayCh[%0d]", k), 32'(evtCh), 32'(vecs[k].expCh));
        checkOutput($sformatf("decayLevel[%0d]", k), 32'(evtLevel), 32'(vecs[k].expLevel));
      end
    end

    // Reload of channel 2 (pointer now at 2), then its release
    expQ.push_back(mkEvt(2'd2, 1'b1));
    expQ.push_back(mkEvt(2'd2, 1'b0));
    for (int s = 1; s <= 16; s++) begin
      applyStimulus(1'b0, 1'b1, (s <= 4) ? 4'h4 : 4'h0, 1'b1);
      if (s == 1) begin
        checkOutput("reloadOut", 32'(outBits), 32'h4);
        checkOutput("reloadValid0", 32'(evtValid), 32'h0);
      end
      if (s == 2) begin
        checkOutput("reloadValid", 32'(evtValid), 32'h1);
        checkOutput("reloadCh", 32'(evtCh), 32'h2);
        checkOutput("reloadLevel", 32'(evtLevel), 32'h1);
      end
      if (s >= 5 && s <= 12) checkOutput($sformatf("holdOut[%0d]", s), 32'(outBits), 32'h4);
      if (s == 13) checkOutput("releaseOut", 32'(outBits), 32'h0);
      if (s == 14) begin
        checkOutput("releaseValid", 32'(evtValid), 32'h1);
        checkOutput("releaseCh", 32'(evtCh), 32'h2);
      end
    end

    // Freeze mid-decay
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    for (int s = 1; s <= 5; s++) begin
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
      if (s == 4) checkOutput("preFrzWrap", 32'(scanWrap), 32'h1);
    end
    for (int s = 1; s <= 10; s++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
      checkOutput($sformatf("frzOut[%0d]", s), 32'(outBits), 32'hF);
      checkOutput($sformatf("frzWrap[%0d]", s), 32'(scanWrap), 32'h0);
      checkOutput($sformatf("frzValid[%0d]", s), 32'(evtValid), 32'h0);
    end
    for (int c = 0; c < 4; c++) expQ.push_back(mkEvt(2'(c), 1'b0));
    for (int r = 1; r <= 13; r++) begin
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
      checkOutput($sformatf("resumeOut[%0d]", r), 32'(outBits), 32'(frzOut[r-1]));
      checkOutput($sformatf("resumeWrap[%0d]", r), 32'(scanWrap), (r == 3 || r == 7 || r == 11) ? 32'h1 : 32'h0);
    end

    // Backpressure and event collisions (idle steps bring the pointer to 1)
    for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b1, 4'h0, 1'b1);
    expQ.push_back(mkEvt(2'd1, 1'b1));
    expQ.push_back(mkEvt(2'd3, 1'b1));
    expQ.push_back(mkEvt(2'd3, 1'b0));
    expQ.push_back(mkEvt(2'd1, 1'b0));
    expQ.push_back(mkEvt(2'd1, 1'b1));
    for (int k = 1; k <= 37; k++) begin
      stim = (k <= 9) ? 4'hA : (k >= 29) ? 4'h8 : (k >= 25) ? 4'h2 : 4'h0;
      rdy  = ((k >= 7 && k <= 9) || (k >= 24 && k <= 28)) ? 1'b1 : 1'b0;
      applyStimulus(1'b0, 1'b1, stim, rdy);
      if (k >= 2 && k <= 6) begin
        checkOutput($sformatf("bpValid[%0d]", k), 32'(evtValid), 32'h1);
        checkOutput($sformatf("bpCh[%0d]", k), 32'(evtCh), 32'h1);
        checkOutput($sformatf("bpLevel[%0d]", k), 32'(evtLevel), 32'h1);
      end
      if (k == 3) checkOutput("bpOut", 32'(outBits), 32'hA);
      if (k == 7 || k == 9 || k == 24 || k == 26 || k == 28)
        checkOutput($sformatf("bpIdle[%0d]", k), 32'(evtValid), 32'h0);
      if (k == 8 || k == 20 || k == 23 || k == 25 || k == 27)
        checkOutput($sformatf("bpLoad[%0d]", k), 32'(evtValid), 32'h1);
      if (k == 8 || k == 20 || k == 23) checkOutput($sformatf("bpLoadCh[%0d]", k), 32'(evtCh), 32'h3);
      if (k == 25 || k == 27) checkOutput($sformatf("bpLoadCh[%0d]", k), 32'(evtCh), 32'h1);
      if (k == 25) begin
        checkOutput("collideLevel", 32'(evtLevel), 32'h0);
        checkOutput("collideOut", 32'(outBits), 32'h2);
      end
      if (k == 27) checkOutput("retainLevel", 32'(evtLevel), 32'h1);
      if (k == 21) checkOutput("bpFallOut", 32'(outBits), 32'h0);
      if (k == 37) begin
        checkOutput("midValid", 32'(evtValid), 32'h1);
        checkOutput("midCh", 32'(evtCh), 32'h3);
        checkOutput("midOut", 32'(outBits), 32'h8);
      end
    end

    // Mid-operation reset drops the presented and pending events
    applyStimulus(1'b1, 1'b1, 4'h0, 1'b0);
    checkOutput("midRstOut", 32'(outBits), 32'hF);
    checkOutput("midRstValid", 32'(evtValid), 32'h0);
    checkOutput("midRstCh", 32'(evtCh), 32'h0);
    checkOutput("midRstLevel", 32'(evtLevel), 32'h0);
    checkOutput("midRstWrap", 32'(scanWrap), 32'h0);
    for (int s = 1; s <= 6; s++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
      checkOutput($sformatf("postRstValid[%0d]", s), 32'(evtValid), 32'h0);
    end
    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/filter_scan_ctrl.md
# filter_scan_ctrl

Time-multiplexed controller that shares one hold-filter update unit among `CHANNELS` command inputs. It visits one channel per clock in round-robin order. On each visit it applies the per-channel countdown-hold rule and stores the result in a per-channel counter bank. Every change of a filtered output is reported over a valid/ready event port, so the command logic downstream gets level-change notifications instead of polling a wide bus.

## Interface
- `CHANNELS`, default 8: number of filtered inputs. Must be ≥ 2.
- `FILTER_WIDTH`, default 2: counter width per channel. Hold length is 2^FILTER_WIDTH − 1 visits.
- `CH_W`, default $clog2(CHANNELS): channel index width. Derived; not overridden.
- `clk` in 1: clock. All state changes on its rising edge.
- `aclr` in 1: reset. Synchronous, active-high.
- `en` in 1: scan enable. While 0, the pointer and counters freeze.
- `in` in CHANNELS: raw command inputs. Bit n belongs to channel n.
- `out` in the output direction, CHANNELS wide: filtered levels. Registered.
- `evt_valid` out 1: an event is presented.
- `evt_ready` in 1: consumer accepts the event.
- `evt_ch` out CH_W: channel index of the presented event.
- `evt_level` out 1: new level of that channel.
- `scan_wrap` out 1: one-cycle pulse when the channel `CHANNELS−1` visit completes.

## Operation
- State:
  - counter bank `cnt[CHANNELS]`, each FILTER_WIDTH bits;
  - scan pointer `ptr` (CH_W bits);
  - register `out`;
  - `pending` mask (CHANNELS bits);
  - event register (`evt_valid`, `evt_ch`, `evt_level`).
- Reset (`aclr`=1 at a rising edge) sets:
  - every `cnt` to all-ones;
  - `out` to all-ones;
  - `ptr`=0, `pending`=0;
  - `evt_valid`=0, `evt_ch`=0, `evt_level`=0, `scan_wrap`=0.
- `aclr` has priority over all other inputs. Reset while an event is presented drops the event. There is no handshake completion.
- Visit (`en`=1), for channel c=`ptr`:
  - if `in[c]`=1: `cnt[c]` ← all-ones;
  - else if `cnt[c]`≠0: `cnt[c]` ← `cnt[c]`−1;
  - else: hold at 0, with no wrap below zero;
  - `out[c]` ← (new `cnt[c]` ≠ 0);
  - the other channels' `cnt` and `out` bits are untouched.
- Pointer: `ptr` increments each visit. From CHANNELS−1 it wraps to 0. `scan_wrap`=1 in the cycle after the visit to CHANNELS−1.
- `en`=0: no visit. `ptr`, `cnt` and `out` hold, and `scan_wrap`=0. The event port keeps operating.
- `in[c]` is sampled only during the visit to c. A pulse that misses the visit is not seen. Producers must hold `in` for ≥ CHANNELS cycles.
- Change detection: if a visit changes `out[c]`, `pending[c]` is set in that cycle.
- Event load: when `evt_valid`=0 and `pending`≠0:
  - pick the lowest set index p;
  - next cycle: `evt_valid`=1, `evt_ch`=p, `evt_level`=`out[p]`, and `pending[p]` is cleared.
- Handshake: `evt_valid`=1 and `evt_ready`=1 at an edge completes the transfer, so `evt_valid`=0 next cycle.
  - At most one event completes per two cycles: complete, then load.
  - While `evt_valid`=1 and `evt_ready`=0, `evt_ch` and `evt_level` are stable.
- Simultaneous events:
  - If the visit sets `pending[p]` in the same cycle the load clears it, the set wins.
  - A channel that toggles twice before reporting yields one event carrying the level at load time.
  - The currently presented channel may be pending again. It reports again after its handshake.

## Timing
- in → out latency: 1 clock after the visit edge. Worst case from `in` change is CHANNELS cycles.
- Release hold: after `in[c]` falls, `out[c]` stays 1 for 2^FILTER_WIDTH − 1 visits, which is (2^FILTER_WIDTH − 1)·CHANNELS cycles with `en`=1.
- out change → `evt_valid` is at least 1 cycle:
  - `out` changes at edge k;
  - `pending` is set at edge k;
  - the event loads at edge k+1 at the earliest.
- `evt_valid` must not depend combinationally on `evt_ready`.
- All outputs are registered.

## Test plan
- Reset with CHANNELS=4, FILTER_WIDTH=2: assert `aclr` with `in`=0 → next cycle `out`=4'b1111, `evt_valid`=0, `ptr`=0, `scan_wrap`=0.
- Release decay: `aclr`→0, `en`=1, `in`=0, `evt_ready`=1 →
  - `out[0]`=0 after the edge of relative cycle 8, and `out[3]`=0 after cycle 11;
  - events are ch 0,1,2,3 in order, all with `evt_level`=0;
  - `scan_wrap` pulses every 4 cycles.
- Reload: with all `out`=0, hold `in[2]`=1 for 4 cycles → `out[2]`=1 one cycle after the ch2 visit, then exactly one event with ch=2, level=1. `in[2]`→0 → `out[2]` falls after 3 further ch2 visits.
- Freeze: `en`=0 for 10 cycles mid-decay → `ptr`, `cnt` and `out` unchanged, `scan_wrap`=0. Resuming continues from the frozen `ptr`.
- Backpressure:
  - hold `evt_ready`=0 while ch1 and ch3 change → `evt_valid` stays 1 with ch=1, stable;
  - `pending`=4'b1000;
  - on `evt_ready`=1, ch1 completes, then ch3 loads on the following edge;
  - a re-set of `pending[1]` in the handshake cycle is retained.
- Mid-operation reset: assert `aclr` while `evt_valid`=1 and `pending`≠0 → next cycle everything is at reset values and no further events appear until an `out` change.
